// File: rtl/seq_d001_detector.sv
// Mealy detector for the serial pattern 0,0,1 with a saturating match counter
// and a debug view of the state register.
module seq_d001_detector #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp,
  output logic             det,
  output logic [CNT_W-1:0] det_count,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    S0     = 2'b01,
    S00    = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             det_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    det_d   = 1'b0;
    case (state_q)
      IDLE:    state_d = inp ? IDLE : S0;
      S0:      state_d = inp ? IDLE : S00;
      // A run of zeros keeps the last two as a live prefix; a 1 consumes the match.
      S00: begin
        state_d = inp ? IDLE : S00;
        det_d   = inp;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (det_d && (count_q != '1)) count_d = count_q + 1'b1;
  end

  assign det       = det_d;
  assign det_count = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_d001_detector.sv
// Directed bench for seq_d001_detector: expectations are queued as stimulus is
// driven and popped when the DUT outputs are sampled at the falling edge.
module tb_seq_d001_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inp = 1'b0;
  logic       det, det2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [1:0] st, st2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       edet;
    logic [1:0] est;
    logic [7:0] ec8;
    logic [1:0] ec2;
    string      tag;
  } exp_t;

  exp_t sbq[$];

  seq_d001_detector #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .inp(inp),
    .det(det), .det_count(cnt8), .state_dbg(st)
  );

  seq_d001_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .inp(inp),
    .det(det2), .det_count(cnt2), .state_dbg(st2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic expect_now(input logic [1:0] est, input logic edet,
                            input logic [7:0] ec8, input logic [1:0] ec2,
                            input string tag);
    exp_t e;
    e.edet = edet; e.est = est; e.ec8 = ec8; e.ec2 = ec2; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty got 0 entries exp >0");
      return;
    end
    e = sbq.pop_front();
    checks++;
    assert (det === e.edet) else begin
      errors++; $error("FAIL %s det got %0b exp %0b", e.tag, det, e.edet);
    end
    checks++;
    assert (st === e.est) else begin
      errors++; $error("FAIL %s state_dbg got %02b exp %02b", e.tag, st, e.est);
    end
    checks++;
    assert (cnt8 === e.ec8) else begin
      errors++; $error("FAIL %s det_count got %0d exp %0d", e.tag, cnt8, e.ec8);
    end
    checks++;
    assert (cnt2 === e.ec2) else begin
      errors++; $error("FAIL %s det_count_w2 got %0d exp %0d", e.tag, cnt2, e.ec2);
    end
    checks++;
    assert (det2 === e.edet) else begin
      errors++; $error("FAIL %s det_w2 got %0b exp %0b", e.tag, det2, e.edet);
    end
  endtask

  // Drive one bit for a full cycle; expected values describe the cycle before
  // the edge that consumes the bit.
  task automatic step(input logic b, input logic [1:0] est, input logic edet,
                      input logic [7:0] ec8, input logic [1:0] ec2,
                      input string tag);
    inp = b;
    expect_now(est, edet, ec8, ec2, tag);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] sat_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    // Reset held with inp toggling
    @(posedge clk); #1;
    step(1'b0, 2'b00, 1'b0, 8'd0, 2'd0, "rst_hold0");
    step(1'b1, 2'b00, 1'b0, 8'd0, 2'd0, "rst_hold1");
    rst = 1'b0;

    // Basic match 0,0,1
    step(1'b0, 2'b00, 1'b0, 8'd0, 2'd0, "basic_b0");
    step(1'b0, 2'b01, 1'b0, 8'd0, 2'd0, "basic_b1");
    step(1'b1, 2'b10, 1'b1, 8'd0, 2'd0, "basic_b2");

    // Near misses 1,0,1,0
    step(1'b1, 2'b00, 1'b0, 8'd1, 2'd1, "near_b0");
    step(1'b0, 2'b00, 1'b0, 8'd1, 2'd1, "near_b1");
    step(1'b1, 2'b01, 1'b0, 8'd1, 2'd1, "near_b2");
    step(1'b0, 2'b00, 1'b0, 8'd1, 2'd1, "near_b3");

    // Long zero run from S0: 0,0,0,1
    step(1'b0, 2'b01, 1'b0, 8'd1, 2'd1, "long_b0");
    step(1'b0, 2'b10, 1'b0, 8'd1, 2'd1, "long_b1");
    step(1'b0, 2'b10, 1'b0, 8'd1, 2'd1, "long_b2");
    step(1'b1, 2'b10, 1'b1, 8'd1, 2'd1, "long_b3");

    // Noise tail 1,1,0,0
    step(1'b1, 2'b00, 1'b0, 8'd2, 2'd2, "noise_b0");
    step(1'b1, 2'b00, 1'b0, 8'd2, 2'd2, "noise_b1");
    step(1'b0, 2'b00, 1'b0, 8'd2, 2'd2, "noise_b2");
    step(1'b0, 2'b01, 1'b0, 8'd2, 2'd2, "noise_b3");

    // Now in S00 with no detection pending; a 1 would fire, then reset kills it
    inp = 1'b1;
    #1;
    expect_now(2'b10, 1'b1, 8'd2, 2'd2, "s00_pre_rst");
    compare_head();
    rst = 1'b1;
    #1;
    expect_now(2'b00, 1'b0, 8'd0, 2'd0, "rst_async");
    compare_head();
    #1;
    rst = 1'b0;
    step(1'b1, 2'b00, 1'b0, 8'd0, 2'd0, "post_rst_1");

    // Back-to-back matches, saturation on the narrow counter
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'b00, 1'b0, 8'(k), sat_exp[k], "sat_b0");
      step(1'b0, 2'b01, 1'b0, 8'(k), sat_exp[k], "sat_b1");
      step(1'b1, 2'b10, 1'b1, 8'(k), sat_exp[k], "sat_b2");
    end
    step(1'b1, 2'b00, 1'b0, 8'd5, 2'd3, "sat_final");

    checks++;
    assert (sbq.size() == 0) else begin
      errors++; $error("FAIL scoreboard_drain got %0d exp 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
